// File: rtl/stb_cnt_pkg.sv
// Shared types and defaults for the LSU store-buffer occupancy tracker.
package stb_cnt_pkg;

  localparam int STB_NTHR      = 4;
  localparam int STB_DEPTH     = 8;
  localparam int STB_CNT_W     = 4;
  localparam int STB_STALL_THR = 7;
  localparam int STB_TID_W     = 2;

  typedef enum logic [1:0] {
    THR_RST    = 2'd0,
    THR_ACTIVE = 2'd1,
    THR_DRAIN  = 2'd2
  } thr_state_e;

  function automatic logic [STB_NTHR-1:0] tid_onehot(input logic [STB_TID_W-1:0] tid);
    logic [STB_NTHR-1:0] oh;
    oh      = '0;
    oh[tid] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/stb_cnt_thr.sv
// One thread's store-buffer counter, RST/ACTIVE/DRAIN sequencer and status flags.
// The high-water-mark register exists only when STB_CNT_HWM_EN is defined.
module stb_cnt_thr
  import stb_cnt_pkg::*;
#(
  parameter int DEPTH     = STB_DEPTH,
  parameter int CNT_W     = STB_CNT_W,
  parameter int STALL_THR = STB_STALL_THR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_hit,
  input  logic             deq_hit,
  input  logic             flush_req,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty,
  output logic             stall,
  output logic             flush_done,
  output logic             ctl_reset,
  output logic             ovfl_pls,
  output logic             udfl_pls
`ifdef STB_CNT_HWM_EN
  ,
  output logic [CNT_W-1:0] hwm
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(STALL_THR);

  thr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             stall_q, stall_d;
  logic             flush_done_q, flush_done_d;
  logic             ctl_reset_q, ctl_reset_d;
  logic             inc, dec;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    ovfl_pls     = 1'b0;
    udfl_pls     = 1'b0;
    inc          = enq_hit && (state_q == THR_ACTIVE);
    dec          = deq_hit && (state_q != THR_RST);

    // Enqueues to a draining thread are dropped but still flagged.
    if (enq_hit && (state_q == THR_DRAIN)) ovfl_pls = 1'b1;

    if (inc && !dec) begin
      if (cnt_q == DEPTH_C) ovfl_pls = 1'b1;
      else                  cnt_d    = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) udfl_pls = 1'b1;
      else             cnt_d    = cnt_q - CNT_W'(1);
    end

    unique case (state_q)
      THR_RST:    state_d = THR_ACTIVE;
      THR_ACTIVE: if (flush_req) state_d = THR_DRAIN;
      THR_DRAIN: begin
        if (cnt_d == '0) begin
          state_d      = THR_ACTIVE;
          flush_done_d = 1'b1;
        end
      end
      default:    state_d = THR_RST;
    endcase

    full_d      = (cnt_d == DEPTH_C);
    empty_d     = (cnt_d == '0);
    stall_d     = (cnt_d >= THR_C) || (state_d == THR_DRAIN);
    ctl_reset_d = (state_d == THR_RST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= THR_RST;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      stall_q      <= 1'b0;
      flush_done_q <= 1'b0;
      ctl_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      stall_q      <= stall_d;
      flush_done_q <= flush_done_d;
      ctl_reset_q  <= ctl_reset_d;
    end
  end

  assign cnt        = cnt_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign stall      = stall_q;
  assign flush_done = flush_done_q;
  assign ctl_reset  = ctl_reset_q;

`ifdef STB_CNT_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  // Flush does not clear the mark; only reset does.
  always_comb begin
    hwm_d = hwm_q;
    if (cnt_d > hwm_q) hwm_d = cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: rtl/stb_cnt_tracker.sv
// Per-thread LSU store-buffer occupancy tracker: counts, flags, drain sequencing, sticky errors.
// Define STB_CNT_HWM_EN to add the per-thread high-water-mark output stb_hwm.
module stb_cnt_tracker
  import stb_cnt_pkg::*;
#(
  parameter int NTHR      = STB_NTHR,
  parameter int DEPTH     = STB_DEPTH,
  parameter int CNT_W     = STB_CNT_W,
  parameter int STALL_THR = STB_STALL_THR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_vld,
  input  logic [STB_TID_W-1:0]  enq_tid,
  input  logic                  deq_vld,
  input  logic [STB_TID_W-1:0]  deq_tid,
  input  logic [NTHR-1:0]       flush_req,
  output logic [NTHR*CNT_W-1:0] lsu_ifu_stbcnt,
  output logic [NTHR-1:0]       stb_full,
  output logic [NTHR-1:0]       stb_empty,
  output logic [NTHR-1:0]       stb_stall,
  output logic [NTHR-1:0]       flush_done,
  output logic [NTHR-1:0]       stb_ctl_reset,
  output logic                  ovfl_err,
  output logic                  udfl_err
`ifdef STB_CNT_HWM_EN
  ,
  output logic [NTHR*CNT_W-1:0] stb_hwm
`endif
);

  logic [NTHR-1:0] enq_hit, deq_hit;
  logic [NTHR-1:0] ovfl_pls, udfl_pls;
  logic            ovfl_err_q, ovfl_err_d;
  logic            udfl_err_q, udfl_err_d;

  always_comb begin
    enq_hit = NTHR'(tid_onehot(enq_tid)) & {NTHR{enq_vld}};
    deq_hit = NTHR'(tid_onehot(deq_tid)) & {NTHR{deq_vld}};
  end

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    stb_cnt_thr #(
      .DEPTH     (DEPTH),
      .CNT_W     (CNT_W),
      .STALL_THR (STALL_THR)
    ) u_thr (
      .clk        (clk),
      .rst        (rst),
      .enq_hit    (enq_hit[t]),
      .deq_hit    (deq_hit[t]),
      .flush_req  (flush_req[t]),
      .cnt        (lsu_ifu_stbcnt[t*CNT_W +: CNT_W]),
      .full       (stb_full[t]),
      .empty      (stb_empty[t]),
      .stall      (stb_stall[t]),
      .flush_done (flush_done[t]),
      .ctl_reset  (stb_ctl_reset[t]),
      .ovfl_pls   (ovfl_pls[t]),
      .udfl_pls   (udfl_pls[t])
`ifdef STB_CNT_HWM_EN
      ,
      .hwm        (stb_hwm[t*CNT_W +: CNT_W])
`endif
    );
  end

  always_comb begin
    ovfl_err_d = ovfl_err_q | (|ovfl_pls);
    udfl_err_d = udfl_err_q | (|udfl_pls);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovfl_err_q <= 1'b0;
      udfl_err_q <= 1'b0;
    end else begin
      ovfl_err_q <= ovfl_err_d;
      udfl_err_q <= udfl_err_d;
    end
  end

  assign ovfl_err = ovfl_err_q;
  assign udfl_err = udfl_err_q;

endmodule

// File: tb/tb_stb_cnt_tracker.sv
// Directed scenarios plus randomized traffic checked each cycle against a behavioural occupancy model.
module tb_stb_cnt_tracker;

  localparam int NTHR      = 4;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 4;
  localparam int STALL_THR = 7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enq_vld;
  logic [1:0]            enq_tid;
  logic                  deq_vld;
  logic [1:0]            deq_tid;
  logic [NTHR-1:0]       flush_req;
  logic [NTHR*CNT_W-1:0] lsu_ifu_stbcnt;
  logic [NTHR-1:0]       stb_full, stb_empty, stb_stall, flush_done, stb_ctl_reset;
  logic                  ovfl_err, udfl_err;
`ifdef STB_CNT_HWM_EN
  logic [NTHR*CNT_W-1:0] stb_hwm;
`endif

  stb_cnt_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .enq_vld        (enq_vld),
    .enq_tid        (enq_tid),
    .deq_vld        (deq_vld),
    .deq_tid        (deq_tid),
    .flush_req      (flush_req),
    .lsu_ifu_stbcnt (lsu_ifu_stbcnt),
    .stb_full       (stb_full),
    .stb_empty      (stb_empty),
    .stb_stall      (stb_stall),
    .flush_done     (flush_done),
    .stb_ctl_reset  (stb_ctl_reset),
    .ovfl_err       (ovfl_err),
    .udfl_err       (udfl_err)
`ifdef STB_CNT_HWM_EN
    ,
    .stb_hwm        (stb_hwm)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: occupancy per thread plus "in reset" / "draining" status.
  int m_cnt  [NTHR];
  int m_hwm  [NTHR];
  bit m_rst  [NTHR];
  bit m_drain[NTHR];
  bit m_done [NTHR];
  bit m_ovfl, m_udfl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int t = 0; t < NTHR; t++) begin
      bit e, d, acc;
      e = enq_vld && (int'(enq_tid) == t);
      d = deq_vld && (int'(deq_tid) == t);
      m_done[t] = 1'b0;
      if (rst) begin
        m_rst[t]   = 1'b1;
        m_drain[t] = 1'b0;
        m_cnt[t]   = 0;
        m_hwm[t]   = 0;
      end else if (m_rst[t]) begin
        m_rst[t] = 1'b0;
      end else begin
        acc = e && !m_drain[t];
        if (e && m_drain[t]) m_ovfl = 1'b1;
        if (acc && !d) begin
          if (m_cnt[t] == DEPTH) m_ovfl = 1'b1;
          else                   m_cnt[t] = m_cnt[t] + 1;
        end else if (d && !acc) begin
          if (m_cnt[t] == 0) m_udfl = 1'b1;
          else               m_cnt[t] = m_cnt[t] - 1;
        end
        if (m_cnt[t] > m_hwm[t]) m_hwm[t] = m_cnt[t];
        if (m_drain[t]) begin
          if (m_cnt[t] == 0) begin
            m_drain[t] = 1'b0;
            m_done[t]  = 1'b1;
          end
        end else if (flush_req[t]) begin
          m_drain[t] = 1'b1;
        end
      end
    end
    if (rst) begin
      m_ovfl = 1'b0;
      m_udfl = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [NTHR-1:0] e_full, e_empty, e_stall, e_done, e_ctl;
    for (int t = 0; t < NTHR; t++) begin
      chk($sformatf("cnt%0d", t), 32'(lsu_ifu_stbcnt[t*CNT_W +: CNT_W]), 32'(m_cnt[t]));
`ifdef STB_CNT_HWM_EN
      chk($sformatf("hwm%0d", t), 32'(stb_hwm[t*CNT_W +: CNT_W]), 32'(m_hwm[t]));
`endif
      e_full[t]  = (m_cnt[t] == DEPTH);
      e_empty[t] = (m_cnt[t] == 0);
      e_stall[t] = (m_cnt[t] >= STALL_THR) || m_drain[t];
      e_done[t]  = m_done[t];
      e_ctl[t]   = m_rst[t];
    end
    chk("full",       32'(stb_full),      32'(e_full));
    chk("empty",      32'(stb_empty),     32'(e_empty));
    chk("stall",      32'(stb_stall),     32'(e_stall));
    chk("flush_done", 32'(flush_done),    32'(e_done));
    chk("ctl_reset",  32'(stb_ctl_reset), 32'(e_ctl));
    chk("ovfl_err",   32'(ovfl_err),      32'(m_ovfl));
    chk("udfl_err",   32'(udfl_err),      32'(m_udfl));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit r, input bit ev, input int et, input bit dv, input int dt,
                       input logic [NTHR-1:0] fl);
    rst       = r;
    enq_vld   = ev;
    enq_tid   = 2'(et);
    deq_vld   = dv;
    deq_tid   = 2'(dt);
    flush_req = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 0, '0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 0, 1'b0, 0, '0);
    step();
    idle();
    step();
  endtask

  task automatic fill(input int tid, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, tid, 1'b0, 0, '0);
      step();
    end
    idle();
  endtask

  initial begin
    int pe, pd;
    drive(1'b1, 1'b0, 0, 1'b0, 0, '0);

    // Reset release
    for (int i = 0; i < 3; i++) step();
    chk("rst_ctl", 32'(stb_ctl_reset), 32'h F);
    chk("rst_empty", 32'(stb_empty), 32'h F);
    chk("rst_cnt", 32'(lsu_ifu_stbcnt), 32'h0);
    idle();
    #2;
    chk("rel_ctl_hold", 32'(stb_ctl_reset), 32'h F);
    step();
    chk("rel_ctl_drop", 32'(stb_ctl_reset), 32'h0);

    // Fill thread 2 to full, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 2, 1'b0, 0, '0);
      step();
      chk("fill_cnt2", 32'(lsu_ifu_stbcnt[11:8]), 32'(i + 1));
      chk("fill_stall2", 32'(stb_stall[2]), 32'((i + 1) >= STALL_THR));
    end
    chk("fill_full2", 32'(stb_full[2]), 32'h1);
    step();
    chk("ovf_cnt2", 32'(lsu_ifu_stbcnt[11:8]), 32'd8);
    chk("ovf_err", 32'(ovfl_err), 32'h1);
    idle();

    // Simultaneous enq+deq at full, then underflow
    do_reset();
    fill(1, DEPTH);
    drive(1'b0, 1'b1, 1, 1'b1, 1, '0);
    step();
    chk("sim_cnt1", 32'(lsu_ifu_stbcnt[7:4]), 32'd8);
    chk("sim_ovfl", 32'(ovfl_err), 32'h0);
    drive(1'b0, 1'b0, 0, 1'b1, 0, '0);
    step();
    chk("udf_err", 32'(udfl_err), 32'h1);
    chk("udf_cnt0", 32'(lsu_ifu_stbcnt[3:0]), 32'h0);
    idle();

    // Drain thread 3 from count 3
    do_reset();
    fill(3, 3);
    drive(1'b0, 1'b0, 0, 1'b0, 0, 4'b1000);
    step();
    chk("drn_stall3", 32'(stb_stall[3]), 32'h1);
    drive(1'b0, 1'b1, 3, 1'b0, 0, '0);
    step();
    chk("drn_drop_cnt3", 32'(lsu_ifu_stbcnt[15:12]), 32'd3);
    chk("drn_drop_ovfl", 32'(ovfl_err), 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 0, 1'b1, 3, '0);
      step();
      chk("drn_cnt3", 32'(lsu_ifu_stbcnt[15:12]), 32'(2 - i));
      chk("drn_done3", 32'(flush_done[3]), 32'(i == 2));
    end
    idle();
    step();
    chk("drn_done3_off", 32'(flush_done[3]), 32'h0);
    chk("drn_stall3_off", 32'(stb_stall[3]), 32'h0);

    // Flush an empty thread 0
    drive(1'b0, 1'b0, 0, 1'b0, 0, 4'b0001);
    step();
    idle();
    chk("emp_done_n1", 32'(flush_done[0]), 32'h0);
    step();
    chk("emp_done_n2", 32'(flush_done[0]), 32'h1);
    step();
    chk("emp_done_n3", 32'(flush_done[0]), 32'h0);

    // Reset in the middle of a drain
    do_reset();
    fill(2, 5);
    drive(1'b0, 1'b0, 0, 1'b0, 0, 4'b0100);
    step();
    drive(1'b1, 1'b0, 0, 1'b0, 0, '0);
    step();
    chk("mid_cnt2", 32'(lsu_ifu_stbcnt[11:8]), 32'h0);
    chk("mid_ctl2", 32'(stb_ctl_reset[2]), 32'h1);
    chk("mid_done", 32'(flush_done), 32'h0);
    chk("mid_errs", 32'({ovfl_err, udfl_err}), 32'h0);
    idle();
    step();

    // Randomized traffic with shifting enqueue/dequeue bias
    pe = 60;
    pd = 40;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        pe = (pe == 60) ? 30 : 60;
        pd = 100 - pe;
      end
      rst       = ($urandom_range(0, 149) == 0);
      enq_vld   = ($urandom_range(0, 99) < pe);
      enq_tid   = 2'($urandom_range(0, 3));
      deq_vld   = ($urandom_range(0, 99) < pd);
      deq_tid   = 2'($urandom_range(0, 3));
      flush_req = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/stb_cnt_tracker.md
Name: stb_cnt_tracker

Overview:
- Per-thread store-buffer occupancy tracker in the LSU.
- Drives the per-thread counts `lsu_ifu_stbcnt*` and per-thread `stb_ctl_reset` consumed by the IFU and by the store-buffer overflow monitor.
- Counts allocations and commit-acks per thread, produces full/empty/stall, and sequences per-thread flush (drain-to-empty).
- Flags overflow/underflow protocol errors as sticky bits.

Parameters:
- NTHR, 4, number of hardware threads.
- DEPTH, 8, store-buffer entries per thread.
- CNT_W, 4, count width; must hold DEPTH.
- STALL_THR, 7, count at or above which `stb_stall` asserts.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- enq_vld  in  1  store allocated this cycle.
- enq_tid  in  2  thread of allocation.
- deq_vld  in  1  store committed (L2 ack) this cycle.
- deq_tid  in  2  thread of commit.
- flush_req  in  NTHR  per-thread drain request (pulse).
- lsu_ifu_stbcnt  out  NTHR*CNT_W  packed counts; thread t at [t*CNT_W +: CNT_W].
- stb_full  out  NTHR  count == DEPTH.
- stb_empty  out  NTHR  count == 0.
- stb_stall  out  NTHR  count >= STALL_THR, or thread in DRAIN.
- flush_done  out  NTHR  one-cycle pulse when a drain completes.
- stb_ctl_reset  out  NTHR  high while thread is in RST state.
- ovfl_err  out  1  sticky; enqueue to full thread or to draining thread.
- udfl_err  out  1  sticky; dequeue from empty thread.

Behaviour:
- All outputs are registered. Inputs sampled at cycle N are visible at cycle N+1.
- Reset: while `rst`=1, every thread is in RST with count=0.
  - Output values: stbcnt=0, stb_empty=all 1, stb_full=0, stb_stall=0, flush_done=0, stb_ctl_reset=all 1, ovfl_err=0, udfl_err=0.
  - First cycle after `rst` falls: RST->ACTIVE, so stb_ctl_reset drops one cycle later.
  - `rst` asserted mid-operation (including mid-drain) returns immediately to the reset state; no flush_done pulse.
- Per-thread FSM: RST, ACTIVE, DRAIN.
  - RST->ACTIVE: `rst` low.
  - ACTIVE->DRAIN: flush_req[t].
  - DRAIN->ACTIVE: next-count==0; registered flush_done[t]=1 for exactly one cycle.
  - flush_req while in DRAIN or RST: ignored.
  - flush_req with count already 0: DRAIN for one cycle, then ACTIVE; flush_done is visible 2 cycles after the request.
- Count update per thread:
  - inc = enq_vld & enq_tid==t & state==ACTIVE.
  - dec = deq_vld & deq_tid==t.
  - inc & dec: count unchanged, even at DEPTH or 0; no error.
  - inc only, count<DEPTH: count+1.
  - inc only, count==DEPTH: count held at DEPTH (saturate), ovfl_err set.
  - dec only, count>0: count-1.
  - dec only, count==0: count held at 0, udfl_err set.
  - Enqueue to thread in DRAIN: dropped, ovfl_err set. Enqueue to thread in RST: dropped silently.
- Dequeues are honoured in DRAIN (drain proceeds via commits) and ignored in RST.
- Enqueue and dequeue on different tids in the same cycle update independently.
- Error bits clear only on `rst`.

Optional Feature:
- STB_CNT_HWM_EN: adds output `stb_hwm` (NTHR*CNT_W), the per-thread high-water mark of count.
  - Updated whenever next-count > hwm. Cleared by `rst` only; not cleared by flush.
- Without the macro, the port and its registers are absent.

Decomposition:
- Package stb_cnt_pkg: thread-state enum (RST/ACTIVE/DRAIN), default NTHR/DEPTH/CNT_W/STALL_THR constants, and a tid-to-onehot decode function.
- Sub-module stb_cnt_thr: one thread's counter, FSM, flags and per-thread error pulses; instantiated NTHR times.
- Top level: enq/deq decode, packing of outputs, and OR-reduce of per-thread error pulses into the sticky ovfl_err/udfl_err.

Test Plan:
- Reset release: rst 1 for 3 cycles, then 0 -> stb_ctl_reset=4'hF through the first post-reset cycle, then 4'h0; all counts 0; stb_empty=4'hF.
- Fill T2: 8 consecutive enq (tid=2) -> count2 steps 1..8; stb_stall[2] rises with count=7; stb_full[2]=1. A 9th enq -> count2 stays 8, ovfl_err=1.
- Simultaneous events: T1 at count 8, enq+deq on tid=1 in the same cycle -> count1 stays 8, ovfl_err stays 0. Then deq tid=0 at count 0 -> udfl_err=1, count0 stays 0.
- Drain: T3 at count 3, flush_req[3] -> stb_stall[3]=1. An enq tid=3 is dropped and sets ovfl_err. Three deq tid=3 -> count 2,1,0; flush_done[3] pulses once in the cycle count reads 0, then state ACTIVE and stb_stall[3]=0.
- Flush when empty: T0 count 0, flush_req[0] at cycle N -> flush_done[0]=1 at cycle N+2 only.
- Reset mid-drain: T2 in DRAIN at count 5, rst pulsed for 1 cycle -> count2=0, stb_ctl_reset[2]=1, no flush_done, ovfl_err/udfl_err=0.
